hazard_pipe_ctrl: RTL and testbench

HAZARD_PIPE_CTRL -- requirements
Module: hazard_pipe_ctrl

---
 rtl/hazard_pipe_ctrl_if.sv | 38 +++
 rtl/hazard_pipe_ctrl.sv | 103 ++++++++++
 tb/tb_hazard_pipe_ctrl.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_pipe_ctrl_if.sv
// ID/EM hazard-control bundle: ID-stage fields and memory handshake in, EM-stage
// fields and pipeline stall/flush controls out.
interface hazard_pipe_ctrl_if;
   logic       id_valid_i;
   logic [2:0] id_rs_addr_i;
   logic [2:0] id_rt_addr_i;
   logic       id_uses_rt_i;
   logic [2:0] id_write_addr_i;
   logic       id_regwrite_i;
   logic       id_memread_i;
   logic       em_branch_taken_i;
   logic       mem_ready_i;

   logic       em_valid_o;
   logic [2:0] em_rs_addr_o;
   logic [2:0] em_rt_addr_o;
   logic [2:0] em_write_addr_o;
   logic       em_regwrite_o;
   logic       em_memread_o;
   logic       pc_stall_o;
   logic       ifid_stall_o;
   logic       ifid_flush_o;
   logic       mem_timeout_o;

   modport master (
      output id_valid_i, id_rs_addr_i, id_rt_addr_i, id_uses_rt_i, id_write_addr_i,
             id_regwrite_i, id_memread_i, em_branch_taken_i, mem_ready_i,
      input  em_valid_o, em_rs_addr_o, em_rt_addr_o, em_write_addr_o, em_regwrite_o,
             em_memread_o, pc_stall_o, ifid_stall_o, ifid_flush_o, mem_timeout_o
   );

   modport slave (
      input  id_valid_i, id_rs_addr_i, id_rt_addr_i, id_uses_rt_i, id_write_addr_i,
             id_regwrite_i, id_memread_i, em_branch_taken_i, mem_ready_i,
      output em_valid_o, em_rs_addr_o, em_rt_addr_o, em_write_addr_o, em_regwrite_o,
             em_memread_o, pc_stall_o, ifid_stall_o, ifid_flush_o, mem_timeout_o
   );
endinterface

// File: rtl/hazard_pipe_ctrl.sv
// Hazard controller for a short pipeline: branch flush, memory-wait stall with
// sticky timeout, and single-bubble load-use interlock in front of the EM stage.
module hazard_pipe_ctrl #(
   parameter int FLUSH_CYCLES = 2,
   parameter int WAIT_LIMIT   = 15
) (
   input  logic               clk_i,
   input  logic               rst_i,
   hazard_pipe_ctrl_if.slave  bus
);
   typedef enum logic {RUN, FLUSH} state_t;

   localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES > 1 ? FLUSH_CYCLES - 2 : 0);
   localparam logic [7:0] WAIT_MAX   = 8'(WAIT_LIMIT);

   state_t     state;
   logic [2:0] flush_cnt;
   logic [7:0] wait_cnt;
   logic       timeout;

   logic       em_valid;
   logic [2:0] em_rs, em_rt, em_wa;
   logic       em_rw, em_mr;

   logic       in_flush, taken, mem_wait, load_use, flush, stall;
   logic [7:0] wait_inc;

   always_comb begin
      in_flush = (state == FLUSH);
      taken    = ~in_flush & em_valid & bus.em_branch_taken_i;
      mem_wait = em_valid & em_memread_w() & ~bus.mem_ready_i;
      load_use = bus.id_valid_i & em_valid & em_mr &
                 ((bus.id_rs_addr_i == em_wa) | (bus.id_uses_rt_i & (bus.id_rt_addr_i == em_wa)));
      flush    = in_flush | taken;
      // Flush dominates, so stalls never coincide with it.
      stall    = ~flush & (mem_wait | load_use);
      wait_inc = (wait_cnt == 8'hFF) ? wait_cnt : wait_cnt + 8'd1;
   end

   function automatic logic em_memread_w();
      return em_mr;
   endfunction

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state     <= RUN;
         flush_cnt <= 3'd0;
         wait_cnt  <= 8'd0;
         timeout   <= 1'b0;
         em_valid  <= 1'b0;
         em_rs     <= 3'd0;
         em_rt     <= 3'd0;
         em_wa     <= 3'd0;
         em_rw     <= 1'b0;
         em_mr     <= 1'b0;
      end else if (mem_wait && !flush) begin
         // EM holds while the load is outstanding.
         wait_cnt <= wait_inc;
         if (wait_inc >= WAIT_MAX) timeout <= 1'b1;
      end else begin
         wait_cnt <= 8'd0;
         if (flush || load_use) begin
            em_valid <= 1'b0;
            em_rs    <= 3'd0;
            em_rt    <= 3'd0;
            em_wa    <= 3'd0;
            em_rw    <= 1'b0;
            em_mr    <= 1'b0;
         end else begin
            em_valid <= bus.id_valid_i;
            em_rs    <= bus.id_rs_addr_i;
            em_rt    <= bus.id_rt_addr_i;
            em_wa    <= bus.id_write_addr_i;
            em_rw    <= bus.id_valid_i & bus.id_regwrite_i;
            em_mr    <= bus.id_valid_i & bus.id_memread_i;
         end
         case (state)
            RUN: begin
               if (taken && FLUSH_CYCLES > 1) begin
                  state     <= FLUSH;
                  flush_cnt <= FLUSH_INIT;
               end
            end
            FLUSH: begin
               if (flush_cnt == 3'd0) state <= RUN;
               else                   flush_cnt <= flush_cnt - 3'd1;
            end
            default: state <= RUN;
         endcase
      end
   end

   assign bus.em_valid_o      = em_valid;
   assign bus.em_rs_addr_o    = em_rs;
   assign bus.em_rt_addr_o    = em_rt;
   assign bus.em_write_addr_o = em_wa;
   assign bus.em_regwrite_o   = em_rw;
   assign bus.em_memread_o    = em_mr;
   assign bus.pc_stall_o      = stall;
   assign bus.ifid_stall_o    = stall;
   assign bus.ifid_flush_o    = flush;
   assign bus.mem_timeout_o   = timeout;
endmodule

// File: tb/tb_hazard_pipe_ctrl.sv
// Bench for hazard_pipe_ctrl: two instances (2- and 3-cycle flush) driven in
// lockstep, scored against a bubble-count reference model each cycle.
module tb_hazard_pipe_ctrl;
   localparam int FA = 2;
   localparam int FB = 3;
   localparam int WL = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       id_valid, uses_rt, rw, mr, br, rdy;
   logic [2:0] rs, rt, wa;
   int         n_chk = 0;
   int         n_fail = 0;

   hazard_pipe_ctrl_if ifa ();
   hazard_pipe_ctrl_if ifb ();

   assign ifa.id_valid_i = id_valid;  assign ifb.id_valid_i = id_valid;
   assign ifa.id_rs_addr_i = rs;      assign ifb.id_rs_addr_i = rs;
   assign ifa.id_rt_addr_i = rt;      assign ifb.id_rt_addr_i = rt;
   assign ifa.id_uses_rt_i = uses_rt; assign ifb.id_uses_rt_i = uses_rt;
   assign ifa.id_write_addr_i = wa;   assign ifb.id_write_addr_i = wa;
   assign ifa.id_regwrite_i = rw;     assign ifb.id_regwrite_i = rw;
   assign ifa.id_memread_i = mr;      assign ifb.id_memread_i = mr;
   assign ifa.em_branch_taken_i = br; assign ifb.em_branch_taken_i = br;
   assign ifa.mem_ready_i = rdy;      assign ifb.mem_ready_i = rdy;

   hazard_pipe_ctrl #(.FLUSH_CYCLES(FA), .WAIT_LIMIT(WL)) dut_a (.clk_i(clk), .rst_i(rst), .bus(ifa));
   hazard_pipe_ctrl #(.FLUSH_CYCLES(FB), .WAIT_LIMIT(WL)) dut_b (.clk_i(clk), .rst_i(rst), .bus(ifb));

   always #5 clk = ~clk;

   // {valid, rs, rt, wa, regwrite, memread, pc_stall, ifid_stall, flush, timeout}
   logic [15:0] obs_a, obs_b;
   assign obs_a = {ifa.em_valid_o, ifa.em_rs_addr_o, ifa.em_rt_addr_o, ifa.em_write_addr_o,
                   ifa.em_regwrite_o, ifa.em_memread_o, ifa.pc_stall_o, ifa.ifid_stall_o,
                   ifa.ifid_flush_o, ifa.mem_timeout_o};
   assign obs_b = {ifb.em_valid_o, ifb.em_rs_addr_o, ifb.em_rt_addr_o, ifb.em_write_addr_o,
                   ifb.em_regwrite_o, ifb.em_memread_o, ifb.pc_stall_o, ifb.ifid_stall_o,
                   ifb.ifid_flush_o, ifb.mem_timeout_o};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference model: EM contents plus "flush bubbles still owed" and a
   // consecutive-wait count.
   typedef struct {
      logic       v;
      logic [2:0] rs, rt, wa;
      logic       rw, mr;
      int         flush_left;
      int         wait_cnt;
      logic       to;
   } em_t;

   em_t ma, mb;

   function automatic em_t m_bubble(em_t s);
      em_t n = s;
      n.v = 0; n.rs = 0; n.rt = 0; n.wa = 0; n.rw = 0; n.mr = 0;
      return n;
   endfunction

   function automatic em_t m_reset();
      em_t n;
      n.flush_left = 0; n.wait_cnt = 0; n.to = 0;
      n.v = 0; n.rs = 0; n.rt = 0; n.wa = 0; n.rw = 0; n.mr = 0;
      return n;
   endfunction

   function automatic logic m_lu(em_t s);
      return id_valid && s.v && s.mr && (rs == s.wa || (uses_rt && rt == s.wa));
   endfunction

   function automatic logic [15:0] m_out(em_t s);
      logic fl, st;
      fl = (s.flush_left > 0) || (s.v && br);
      st = !fl && ((s.v && s.mr && !rdy) || m_lu(s));
      return {s.v, s.rs, s.rt, s.wa, s.rw, s.mr, st, st, fl, s.to};
   endfunction

   function automatic em_t m_step(em_t s, int f_cycles);
      em_t n = s;
      if (s.flush_left > 0 || (s.v && br)) begin
         n = m_bubble(s);
         n.flush_left = (s.flush_left > 0) ? s.flush_left - 1 : f_cycles - 1;
         n.wait_cnt = 0;
      end else if (s.v && s.mr && !rdy) begin
         n.wait_cnt = (s.wait_cnt < 255) ? s.wait_cnt + 1 : 255;
         if (n.wait_cnt >= WL) n.to = 1;
      end else begin
         if (m_lu(s)) n = m_bubble(s);
         else begin
            n.v = id_valid; n.rs = rs; n.rt = rt; n.wa = wa;
            n.rw = id_valid & rw; n.mr = id_valid & mr;
         end
         n.wait_cnt = 0;
      end
      return n;
   endfunction

   task automatic step_cycle();
      @(negedge clk);
      chk("model_a", obs_a, m_out(ma));
      chk("model_b", obs_b, m_out(mb));
      @(posedge clk);
      if (rst) begin
         ma = m_reset(); mb = m_reset();
      end else begin
         ma = m_step(ma, FA); mb = m_step(mb, FB);
      end
      #1;
   endtask

   task automatic set_id(input logic v, input logic [2:0] a, input logic [2:0] b,
                         input logic u, input logic [2:0] w, input logic r, input logic m);
      id_valid = v; rs = a; rt = b; uses_rt = u; wa = w; rw = r; mr = m;
   endtask

   task automatic assert_rst();
      rst = 1'b1;
      ma = m_reset(); mb = m_reset();
      #1;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      br = 0; rdy = 1;
      set_id(0, 0, 0, 0, 0, 0, 0);
      assert_rst();
      chk("reset_a", obs_a, 0);
      chk("reset_b", obs_b, 0);
      step_cycle();
      rst = 0;

      // load-use on rs: one stall, one bubble, then the consumer enters EM
      set_id(1, 1, 2, 1, 3, 1, 1); step_cycle();
      set_id(1, 3, 4, 0, 6, 1, 0); #1;
      chk("lu_pc_stall", ifa.pc_stall_o, 1);
      chk("lu_ifid_stall", ifa.ifid_stall_o, 1);
      step_cycle(); #1;
      chk("lu_bubble", ifa.em_valid_o, 0);
      chk("lu_one_cycle", ifa.pc_stall_o, 0);
      step_cycle();
      chk("lu_enter_valid", ifa.em_valid_o, 1);
      chk("lu_enter_rs", ifa.em_rs_addr_o, 3);

      // rt match ignored when rt is not read
      set_id(1, 0, 0, 0, 5, 1, 1); step_cycle();
      set_id(1, 2, 5, 0, 1, 1, 0); #1;
      chk("rt_gate_stall", ifa.pc_stall_o, 0);
      step_cycle();
      chk("rt_gate_adv", ifa.em_rs_addr_o, 2);

      // taken branch with two flush cycles
      br = 1; set_id(1, 7, 7, 0, 7, 1, 0); #1;
      chk("br_flush0", ifa.ifid_flush_o, 1);
      chk("br_nostall", ifa.pc_stall_o, 0);
      step_cycle(); br = 0; #1;
      chk("br_flush1", ifa.ifid_flush_o, 1);
      chk("br_bubble1", ifa.em_valid_o, 0);
      step_cycle(); #1;
      chk("br_flush_end", ifa.ifid_flush_o, 0);
      chk("br_bubble2", ifa.em_valid_o, 0);
      step_cycle();
      chk("br_resume", {ifa.em_valid_o, ifa.em_rs_addr_o}, {1'b1, 3'd7});

      // three-cycle memory wait then release
      set_id(1, 0, 0, 0, 4, 1, 1); step_cycle();
      rdy = 0; set_id(1, 1, 1, 0, 2, 1, 0);
      repeat (3) begin
         #1;
         chk("wait_stall", ifa.pc_stall_o, 1);
         chk("wait_hold", ifa.em_write_addr_o, 4);
         step_cycle();
      end
      rdy = 1; #1;
      chk("wait_release", ifa.pc_stall_o, 0);
      chk("wait_no_to", ifa.mem_timeout_o, 0);
      step_cycle();
      chk("wait_adv", ifa.em_write_addr_o, 2);

      // timeout after the fourth wait cycle, sticky until reset
      set_id(1, 0, 0, 0, 4, 1, 1); step_cycle();
      rdy = 0; set_id(1, 1, 1, 0, 2, 1, 0);
      repeat (3) step_cycle();
      chk("to_early", ifa.mem_timeout_o, 0);
      step_cycle();
      chk("to_set", ifa.mem_timeout_o, 1);
      chk("to_still_stall", ifa.pc_stall_o, 1);
      rdy = 1; step_cycle(); step_cycle();
      chk("to_sticky", ifa.mem_timeout_o, 1);
      assert_rst();
      chk("to_cleared", ifa.mem_timeout_o, 0);
      step_cycle();
      rst = 0;

      // reset one cycle into the three-cycle flush
      set_id(1, 1, 2, 0, 3, 1, 0); step_cycle();
      br = 1; step_cycle();
      br = 0;
      chk("flush_b_active", ifb.ifid_flush_o, 1);
      assert_rst();
      chk("rst_flush_b", obs_b, 0);
      chk("rst_flush_a", obs_a, 0);
      step_cycle();
      rst = 0; #1;
      chk("post_rst_flush", ifb.ifid_flush_o, 0);
      step_cycle();
      chk("post_rst_flush2", ifb.ifid_flush_o, 0);

      // randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(99) == 0) assert_rst();
         else rst = 0;
         id_valid = ($urandom_range(9) != 0);
         rs = 3'($urandom_range(7));
         rt = 3'($urandom_range(7));
         wa = 3'($urandom_range(7));
         uses_rt = 1'($urandom_range(1));
         rw = 1'($urandom_range(1));
         mr = ($urandom_range(2) == 0);
         br = ($urandom_range(9) == 0);
         rdy = ($urandom_range(3) != 0);
         step_cycle();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
